// File: rtl/dff_checker.sv
// dff_checker: cycle-accurate reference monitor for a DFF with async reset.
// Compares observed q/qbar against a model every CHECK cycle and counts samples and mismatches.
module dff_checker #(
    parameter int CNT_W = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             d_obs,
    input  logic             rst_obs,
    input  logic             q_obs,
    input  logic             qbar_obs,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, PRIME, CHECK, HALT} state_t;
    state_t state;
    logic exp_q;
    logic mis;
    assign mis = (q_obs != exp_q) || (qbar_obs == q_obs);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            exp_q   <= 1'b0;
            chk_cnt <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // the model tracks the stimulus in every state so PRIME only needs one cycle
            exp_q <= rst_obs ? 1'b0 : d_obs;
            if (clr) begin
                state   <= IDLE;
                chk_cnt <= '0;
                err_cnt <= '0;
                err     <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= en ? PRIME : IDLE;
                        busy  <= en;
                    end
                    PRIME: begin
                        state <= en ? CHECK : IDLE;
                        busy  <= en;
                    end
                    CHECK: begin
                        chk_cnt <= (&chk_cnt) ? chk_cnt : chk_cnt + 1'b1;
                        if (mis) begin
                            err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
                            err     <= 1'b1;
                        end
                        if (mis && STOP_ON_ERR) begin
                            state <= HALT;
                            busy  <= 1'b0;
                        end else if (!en) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    HALT:    state <= HALT;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dff_checker.sv
// tb_dff_checker: scoreboard bench for dff_checker with default, halting and 4-bit-counter instances.
module tb_dff_checker;
    logic clk = 1'b0, reset = 1'b0, clr = 1'b0, en = 1'b0, d_obs = 1'b0, rst_obs = 1'b0;
    logic dq = 1'b0, f0 = 1'b0, fqb = 1'b0;
    logic q_obs, qbar_obs;
    logic [7:0] c0, e0, c1, e1;
    logic [3:0] c2, e2;
    logic r0, r1, r2, b0, b1, b2;
    int n_cmp = 0, n_err = 0;
    typedef struct {string tag; int u; int c; int e; int r; int b;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // reference DFF under observation, with fault injection on its outputs
    always @(posedge clk or posedge rst_obs)
        if (rst_obs) dq <= 1'b0;
        else dq <= d_obs;
    assign q_obs    = f0 ? 1'b0 : dq;
    assign qbar_obs = fqb ? q_obs : ~q_obs;

    dff_checker u0 (.clk(clk), .reset(reset), .clr(clr), .en(en), .d_obs(d_obs), .rst_obs(rst_obs),
        .q_obs(q_obs), .qbar_obs(qbar_obs), .chk_cnt(c0), .err_cnt(e0), .err(r0), .busy(b0));
    dff_checker #(.STOP_ON_ERR(1'b1)) u1 (.clk(clk), .reset(reset), .clr(clr), .en(en), .d_obs(d_obs),
        .rst_obs(rst_obs), .q_obs(q_obs), .qbar_obs(qbar_obs), .chk_cnt(c1), .err_cnt(e1), .err(r1), .busy(b1));
    dff_checker #(.CNT_W(4)) u2 (.clk(clk), .reset(reset), .clr(clr), .en(en), .d_obs(d_obs),
        .rst_obs(rst_obs), .q_obs(q_obs), .qbar_obs(qbar_obs), .chk_cnt(c2), .err_cnt(e2), .err(r2), .busy(b2));

    task automatic check(input string tag, input int obs, input int want_v);
        n_cmp++;
        if (obs !== want_v) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, want_v);
        end
    endtask

    function automatic void want(input string tag, input int u, input int c, input int e, input int r, input int b);
        sb.push_back('{tag, u, c, e, r, b});
    endfunction

    task automatic cyc(input logic dv, input logic rv, input logic ev, input logic cv);
        exp_t x;
        d_obs = dv; rst_obs = rv; en = ev; clr = cv;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check({x.tag, ".chk_cnt"}, x.u == 0 ? int'(c0) : x.u == 1 ? int'(c1) : int'(c2), x.c);
            check({x.tag, ".err_cnt"}, x.u == 0 ? int'(e0) : x.u == 1 ? int'(e1) : int'(e2), x.e);
            check({x.tag, ".err"}, x.u == 0 ? int'(r0) : x.u == 1 ? int'(r1) : int'(r2), x.r);
            check({x.tag, ".busy"}, x.u == 0 ? int'(b0) : x.u == 1 ? int'(b1) : int'(b2), x.b);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        reset = 1'b1;
    endtask

    task automatic prime();
        cyc(0, 1, 1, 0);
        cyc(1, 0, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and idle
        for (int i = 0; i < 2; i++) begin
            want("rst", 0, 0, 0, 0, 0); want("rst", 1, 0, 0, 0, 0); want("rst", 2, 0, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin want("idle", 0, 0, 0, 0, 0); want("idle", 2, 0, 0, 0, 0); end
            cyc(logic'(i % 2), 0, 0, 0);
        end
        // clean run
        want("prime", 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0);
        for (int i = 0; i <= 20; i++) begin
            if (i == 20) want("clean", 0, 20, 0, 0, 1);
            cyc(logic'(i % 2 == 0), 0, 1, 0);
        end
        // q stuck at 0 for three cycles while the model expects 1
        f0 = 1'b1;
        want("qf1", 0, 21, 1, 1, 1);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        want("qf3", 0, 23, 3, 1, 1);
        cyc(1, 0, 1, 0);
        f0 = 1'b0;
        want("qok", 0, 24, 3, 1, 1);
        cyc(1, 0, 1, 0);
        fqb = 1'b1;
        want("qbar", 0, 25, 4, 1, 1);
        cyc(0, 0, 1, 0);
        fqb = 1'b0;
        want("qbarok", 0, 26, 4, 1, 1);
        cyc(1, 0, 1, 0);
        // halt on first mismatch
        do_reset();
        prime();
        for (int k = 1; k <= 5; k++) begin
            fqb = (k == 5);
            if (k == 4) want("pre_halt", 1, 4, 0, 0, 1);
            if (k == 5) want("halt", 1, 5, 1, 1, 0);
            cyc(logic'(k % 2), 0, 1, 0);
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 9) want("frozen", 1, 5, 1, 1, 0);
            cyc(logic'(k % 2), 0, 1, 0);
        end
        fqb = 1'b0;
        want("halt_clr", 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        want("clr_idle", 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // saturation
        do_reset();
        prime();
        fqb = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 14) want("sat14", 2, 14, 14, 1, 1);
            if (k == 15) want("sat15", 2, 15, 15, 1, 1);
            if (k == 20) begin want("sat20", 2, 15, 15, 1, 1); want("wide20", 0, 20, 20, 1, 1); end
            cyc(logic'(k % 2), 0, 1, 0);
        end
        fqb = 1'b0;
        // en dropped mid-CHECK, then re-raised
        do_reset();
        prime();
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) want("en_drop", 0, 6, 0, 0, 0);
            cyc(logic'(k % 2), 0, k < 6, 0);
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 2) want("en_hold", 0, 6, 0, 0, 0);
            cyc(logic'(k % 2), 0, 0, 0);
        end
        want("re_prime", 0, 6, 0, 0, 1);
        cyc(1, 0, 1, 0);
        want("re_check", 0, 6, 0, 0, 1);
        cyc(0, 0, 1, 0);
        want("re_first", 0, 7, 0, 0, 1);
        cyc(1, 0, 1, 0);
        // reset during CHECK
        fqb = 1'b1;
        want("pre_rst", 0, 8, 1, 1, 1);
        cyc(0, 0, 1, 0);
        fqb = 1'b0;
        reset = 1'b0;
        want("mid_rst", 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0);
        reset = 1'b1;
        // clr against a simultaneous mismatch
        prime();
        want("pre_clr", 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0);
        fqb = 1'b1;
        want("clr_mis", 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1);
        fqb = 1'b0;
        want("post_clr", 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dff_checker.md
# dff_checker

Self-checking response monitor for the D flip-flop with asynchronous active-high reset (ports d, clk, reset, q, qbar). It sits on the read side of the flip-flop stimulus path. It observes the same d and DUT-reset the stimulus drives, plus the DUT's q/qbar. It keeps a cycle-accurate reference model of the flip-flop, compares every cycle, and reports checked-sample and mismatch counts plus a sticky error flag. It is synthesizable, so the same check runs in simulation and on-board.

## Interface
Parameters:
- CNT_W, 8: width of chk_cnt and err_cnt; both saturate at 2^CNT_W-1.
- STOP_ON_ERR, 0: 1 = freeze checking after the first mismatch (HALT state); 0 = keep checking.

Ports:
- clk  input  1  checker clock; the same clock as the observed DFF.
- reset  input  1  checker reset; synchronous, active-low.
- clr  input  1  synchronous clear of counters and err; priority below reset.
- en  input  1  checking enable.
- d_obs  input  1  observed DFF d input.
- rst_obs  input  1  observed DFF reset, active-high as seen by the DUT.
- q_obs  input  1  observed DFF q.
- qbar_obs  input  1  observed DFF qbar.
- chk_cnt  output  CNT_W  number of compared cycles.
- err_cnt  output  CNT_W  number of mismatching cycles.
- err  output  1  sticky; set on the first mismatch.
- busy  output  1  1 in PRIME or CHECK.

## Operation
- Reference model exp_q, updated every posedge regardless of state:
  - rst_obs=1 gives 0.
  - otherwise exp_q = d_obs.
- rst_obs is sampled at clk. An asynchronous DUT reset pulse that does not span a posedge is out of scope.
- Mismatch in a cycle: (q_obs != exp_q) OR (qbar_obs != ~q_obs).
- States:
  - IDLE: no compare. en=1 goes to PRIME.
  - PRIME: exactly 1 cycle so exp_q is loaded from live stimulus; no compare. Next state is CHECK if en=1, else IDLE.
  - CHECK: compare every cycle and increment chk_cnt. On a mismatch, increment err_cnt and set err. en=0 goes to IDLE. A mismatch with STOP_ON_ERR=1 goes to HALT.
  - HALT: no compare; counters and err hold. Left only by reset or clr (clr goes to IDLE).
- Counters saturate at 2^CNT_W-1 and never wrap. err stays 1 even if err_cnt has saturated.
- clr (when reset=1):
  - zeroes chk_cnt, err_cnt and err;
  - state goes to IDLE;
  - exp_q keeps updating;
  - clr overrides a simultaneous compare in that cycle.
- en dropped mid-CHECK: the compare in that same cycle still counts; counters hold in IDLE. Re-enabling goes through PRIME and does not clear the counters.

## Timing
- reset=0 at a posedge gives, at that edge:
  - state=IDLE, exp_q=0, chk_cnt=0, err_cnt=0, err=0, busy=0.
- reset overrides clr, en and every state, including HALT.
- Compare alignment at edge k:
  - q_obs is the DUT value produced at edge k-1.
  - exp_q is the model value computed at edge k-1.
  - The relative latency is therefore zero, with no extra pipeline.
- Outputs are registered. A compare at edge k is visible on chk_cnt/err_cnt/err after edge k.
- en rising at edge k:
  - edge k enters PRIME;
  - edge k+1 enters CHECK;
  - the first compare occurs at edge k+2.
- busy=1 from the edge entering PRIME until the edge leaving CHECK.
- A mismatch at edge k with STOP_ON_ERR=1:
  - the mismatch is counted (err_cnt=1);
  - HALT is entered at the same edge;
  - nothing further is counted.

## Test plan
- Reset and idle:
  - Stimulus: reset=0 for 2 cycles, then reset=1, en=0, while toggling d_obs.
  - Required: all outputs 0, busy=0 indefinitely.
- Clean run:
  - Stimulus: en=1; rst_obs=1 for 1 cycle, then d_obs=1 then 0, alternating each 10 ns cycle. q_obs/qbar_obs come from a correct DFF.
  - Required after 20 CHECK cycles: chk_cnt=20, err_cnt=0, err=0.
- Injected fault:
  - Stimulus: clean run, but q_obs forced to 0 for 3 consecutive cycles while the model expects 1.
  - Required: err_cnt=3, err=1 from the first faulty compare, chk_cnt still increments.
  - Also: qbar_obs stuck equal to q_obs for 1 cycle gives err_cnt +1.
- STOP_ON_ERR=1:
  - Stimulus: inject one mismatch at the 5th compare.
  - Required: chk_cnt=5, err_cnt=1, state HALT, busy=0.
  - Counters frozen for 10 more cycles. clr then gives all 0, IDLE.
- Saturation with CNT_W=4:
  - Stimulus: 20 mismatching compares.
  - Required: err_cnt=15, chk_cnt=15, with no wrap.
- Mid-operation events:
  - Sub-case 1, en low: drop en after 6 compares. Required: chk_cnt holds 6. Re-raise en: the first new compare lands 2 edges later.
  - Sub-case 2, reset=0 during CHECK. Required: everything 0 at that edge.
  - Sub-case 3, clr and a mismatch at the same edge. Required: counters 0, err=0.
